key_filter: RTL and testbench
=============================

# key_filter

Four-channel key debouncer feeding `key_control` in the DDS signal generator. Synchronises the raw active-low `key[3:0]` board inputs to `sys_clk` and filters contact bounce with a per-key counter. Emits a debounced level plus a single-cycle press pulse per key, which `key_control` consumes to step `wave_select`. An optional auto-repeat re-pulses a held key.

## Interface
- `CNT_MAX`, 999_999: filter length minus one; a level must be stable for CNT_MAX+1 samples (20 ms at 50 MHz).
- `REPEAT_DLY`, 24_999_999: hold cycles minus one before first auto-repeat (500 ms); used only with KEY_REPEAT_EN.
- `REPEAT_PER`, 4_999_999: auto-repeat period minus one (100 ms); used only with KEY_REPEAT_EN.
- `sys_clk`  input  1  system clock, 50 MHz; the only clock.
- `sys_rst_n`  input  1  reset, synchronous, active-low.
- `key`  input  4  raw key levels, asynchronous, active-low (0 = pressed).
- `key_flag`  output  4  per-key one-cycle press pulse, active-high, registered.
- `key_state`  output  4  per-key debounced level, 1 = pressed, registered.

## Operation
- Each key bit passes through a 2-FF synchroniser (`key_sync`); both stages reset to 1 (released).
- Four identical independent channels; each holds a 2-state FSM (UP, DOWN), a filter counter `filt_cnt` of clog2(CNT_MAX+1) bits, and, when KEY_REPEAT_EN is defined, a repeat counter and a phase bit.
- UP: `filt_cnt` increments each cycle `key_sync`==0 and clears to 0 on any cycle `key_sync`==1. When `filt_cnt`==CNT_MAX and `key_sync`==0, the channel:
  - moves to DOWN,
  - clears `filt_cnt`,
  - sets `key_state`=1,
  - pulses `key_flag` for exactly one cycle.
- DOWN: `filt_cnt` increments each cycle `key_sync`==1 and clears on `key_sync`==0. When `filt_cnt`==CNT_MAX and `key_sync`==1, the channel moves to UP, clears `filt_cnt` and sets `key_state`=0. No flag is generated on release.
- Glitches shorter than CNT_MAX+1 cycles never change state or flag.
- `filt_cnt` never exceeds CNT_MAX; no wrap-around.
- Simultaneous presses on several keys produce `key_flag` bits in the same cycle. There is no priority or masking; `key_control` resolves conflicts.
- Reset (synchronous, `sys_rst_n`==0 at a rising edge) has these effects:
  - all FSMs go to UP and all counters to 0,
  - `key_flag`=4'b0000, `key_state`=4'b0000,
  - synchroniser stages go to 1.
- Reset mid-filter discards progress. A key held through reset is re-filtered from zero and flags once after reset.

## Timing
- Press latency: raw `key` sampled low first at edge 0 and held gives `key_flag` high from edge CNT_MAX+2 to edge CNT_MAX+3 (one cycle). `key_state` rises in the same cycle and stays high.
- Release latency: `key_state` falls CNT_MAX+2 edges after the first stable-high raw sample.
- `key_flag` is never high for two consecutive cycles on one bit.
- Outputs are driven straight from flops; no combinational path from `key`.

## Configuration
- `KEY_REPEAT_EN` defined: in DOWN, the repeat counter resets to 0 on entry and increments every cycle.
  - First repeat: when it equals REPEAT_DLY, `key_flag` pulses, the counter clears and the phase bit sets.
  - Subsequent repeats: with the phase bit set, a pulse occurs each time the counter equals REPEAT_PER, and the counter clears.
  - Pulse spacing is therefore REPEAT_DLY+1 cycles after the press flag, then every REPEAT_PER+1 cycles.
  - Leaving DOWN clears the counter and the phase bit.
  - Release filtering is unaffected by the repeat logic.
- `KEY_REPEAT_EN` undefined: no repeat logic is synthesised; exactly one flag per debounced press.

## Test plan
Bench parameters: CNT_MAX=9, REPEAT_DLY=49, REPEAT_PER=19.
- Reset: hold `sys_rst_n`=0 for 3 edges with `key`=4'b0000 -> `key_flag`=0 and `key_state`=0 throughout; after release, each key flags exactly once at edge 11 (edge 0 = first edge with `sys_rst_n`=1).
- Clean press: `key[0]` low from edge 0 -> `key_flag`=4'b0001 for one cycle after edge 11, `key_state[0]`=1 from edge 11. Release at edge 40 -> `key_state[0]`=0 after edge 51, no flag.
- Bounce: `key[1]` toggles low/high every 3 cycles for 30 cycles, then stays low -> no flag during bouncing; one flag 11 edges after the final low sample.
- Simultaneous: `key[3:2]` low at the same edge -> `key_flag`=4'b1100 in a single cycle.
- Reset mid-filter: `key[0]` low at edge 0, reset asserted at edge 6 -> no flag; after reset release, flag 11 edges later.
- Repeat (with KEY_REPEAT_EN): hold `key[0]` -> flags after edges 11, 61, 81, 101. Without KEY_REPEAT_EN -> only the flag after edge 11.

Source files
------------

// File: rtl/key_filter_if.sv
// key_filter_if: raw key inputs and debounced outputs of key_filter.
// master drives key (board side), slave is the filter itself.
interface key_filter_if;
    logic [3:0] key;
    logic [3:0] key_flag;
    logic [3:0] key_state;

    modport master (
        output key,
        input  key_flag,
        input  key_state
    );

    modport slave (
        input  key,
        output key_flag,
        output key_state
    );
endinterface

// File: rtl/key_filter.sv
// key_filter: four-channel active-low key debouncer with press pulse.
// Define KEY_REPEAT_EN to add auto-repeat pulses on a held key.
module key_filter #(
    parameter int CNT_MAX = 999_999
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DLY = 24_999_999,
    parameter int REPEAT_PER = 4_999_999
`endif
) (
    input logic         sys_clk,
    input logic         sys_rst_n,
    key_filter_if.slave bus
);

    localparam int FW = $clog2(CNT_MAX + 1);
    localparam logic [FW-1:0] CMAX = FW'(CNT_MAX);

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RDLY = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RPER = RW'(REPEAT_PER);
`endif

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } state_e;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_flag;
    logic [3:0] w_level;

    // Two-stage synchroniser; idle level is released (1)
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= bus.key;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        state_e        r_st;
        logic [FW-1:0] r_cnt;
        logic          r_flag;
        logic          r_level;
        logic          w_key;

        assign w_key = r_sync2[g];

`ifdef KEY_REPEAT_EN
        logic [RW-1:0] r_rep;
        logic          r_phase;
        logic          w_rep_hit;

        // First repeat waits REPEAT_DLY, later ones REPEAT_PER
        assign w_rep_hit = r_phase ? (r_rep == RPER) : (r_rep == RDLY);
`endif

        // Per-key debounce FSM with registered level and press pulse
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                r_st    <= ST_UP;
                r_cnt   <= '0;
                r_flag  <= 1'b0;
                r_level <= 1'b0;
`ifdef KEY_REPEAT_EN
                r_rep   <= '0;
                r_phase <= 1'b0;
`endif
            end else begin
                r_flag <= 1'b0;
                unique case (r_st)
                    ST_UP: begin
                        if (w_key) begin
                            r_cnt <= '0;
                        end else if (r_cnt == CMAX) begin
                            r_st    <= ST_DOWN;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_flag  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + FW'(1);
                        end
`ifdef KEY_REPEAT_EN
                        r_rep   <= '0;
                        r_phase <= 1'b0;
`endif
                    end
                    ST_DOWN: begin
`ifdef KEY_REPEAT_EN
                        if (w_rep_hit) begin
                            r_flag  <= 1'b1;
                            r_rep   <= '0;
                            r_phase <= 1'b1;
                        end else begin
                            r_rep <= r_rep + RW'(1);
                        end
`endif
                        if (!w_key) begin
                            r_cnt <= '0;
                        end else if (r_cnt == CMAX) begin
                            r_st    <= ST_UP;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
`ifdef KEY_REPEAT_EN
                            r_rep   <= '0;
                            r_phase <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + FW'(1);
                        end
                    end
                    default: begin
                        r_st <= ST_UP;
                    end
                endcase
            end
        end

        assign w_flag[g]  = r_flag;
        assign w_level[g] = r_level;
    end

    assign bus.key_flag  = w_flag;
    assign bus.key_state = w_level;

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed checks of key_filter with CNT_MAX=9.
// Repeat expectations switch on with KEY_REPEAT_EN.
module tb_key_filter;

`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    key_filter_if bus ();

    key_filter #(
        .CNT_MAX(9)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DLY(49),
        .REPEAT_PER(19)
`endif
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One active edge, then settle to the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run n edges from now (edge 0 = next edge); flag fm expected
    // only after edge fe, state s0 before edge se and s1 from it
    task automatic watch(input string tag, input int n, input int fe,
                         input logic [3:0] fm, input int se,
                         input logic [3:0] s0, input logic [3:0] s1);
        for (int e = 0; e < n; e++) begin
            step();
            chk($sformatf("%s flag e%0d", tag, e), bus.key_flag,
                (e == fe) ? fm : 4'b0000);
            chk($sformatf("%s state e%0d", tag, e), bus.key_state,
                (e >= se) ? s1 : s0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.key  = 4'b0000;

        // Reset with all keys held
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst flag %0d", i), bus.key_flag, 4'b0000);
            chk($sformatf("rst state %0d", i), bus.key_state, 4'b0000);
        end
        rst_n = 1'b1;
        watch("held", 13, 11, 4'b1111, 11, 4'b0000, 4'b1111);
        bus.key = 4'b1111;
        watch("held rel", 13, -1, 4'b0000, 11, 4'b1111, 4'b0000);

        // Clean press of key 0, release at edge 40
        bus.key = 4'b1110;
        watch("clean", 40, 11, 4'b0001, 11, 4'b0000, 4'b0001);
        bus.key = 4'b1111;
        watch("clean rel", 13, -1, 4'b0000, 11, 4'b0001, 4'b0000);

        // Bounce on key 1: 3 low / 3 high for 30 cycles
        for (int i = 0; i < 10; i++) begin
            bus.key = (i % 2 == 0) ? 4'b1101 : 4'b1111;
            for (int j = 0; j < 3; j++) begin
                step();
                chk($sformatf("bounce flag %0d", i * 3 + j),
                    bus.key_flag, 4'b0000);
                chk($sformatf("bounce state %0d", i * 3 + j),
                    bus.key_state, 4'b0000);
            end
        end
        bus.key = 4'b1101;
        watch("bounce", 13, 11, 4'b0010, 11, 4'b0000, 4'b0010);
        bus.key = 4'b1111;
        watch("bounce rel", 13, -1, 4'b0000, 11, 4'b0010, 4'b0000);

        // Simultaneous press of keys 3 and 2
        bus.key = 4'b0011;
        watch("simul", 13, 11, 4'b1100, 11, 4'b0000, 4'b1100);
        bus.key = 4'b1111;
        watch("simul rel", 13, -1, 4'b0000, 11, 4'b1100, 4'b0000);

        // Reset at edge 6 of a key 0 filter run
        bus.key = 4'b1110;
        for (int e = 0; e < 6; e++) begin
            step();
            chk($sformatf("midrst flag e%0d", e), bus.key_flag, 4'b0000);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("midrst in flag %0d", i), bus.key_flag, 4'b0000);
            chk($sformatf("midrst in state %0d", i), bus.key_state, 4'b0000);
        end
        rst_n = 1'b1;
        watch("midrst", 13, 11, 4'b0001, 11, 4'b0000, 4'b0001);
        bus.key = 4'b1111;
        watch("midrst rel", 13, -1, 4'b0000, 11, 4'b0001, 4'b0000);

        // Long hold of key 0: repeats only in the repeat build
        bus.key = 4'b1110;
        for (int e = 0; e < 105; e++) begin
            logic [3:0] ef;
            ef = 4'b0000;
            if (e == 11) ef = 4'b0001;
            if (REP && (e == 61 || e == 81 || e == 101)) ef = 4'b0001;
            step();
            chk($sformatf("hold flag e%0d", e), bus.key_flag, ef);
            chk($sformatf("hold state e%0d", e), bus.key_state,
                (e >= 11) ? 4'b0001 : 4'b0000);
        end
        bus.key = 4'b1111;
        watch("hold rel", 13, -1, 4'b0000, 11, 4'b0001, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
